// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its requester arbiter: op codes,
// flag bit positions and the response-register state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Response register occupancy; the encoding doubles as rsp_valid.
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU. Unknown op codes execute as add. For sub, the carry
// flag reports an unsigned borrow (a < b); logic, compare and shift ops
// clear carry and overflow.
module alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] res,
    output logic [3:0]   flags
);

    localparam int SHW = $clog2(N);

    logic [N:0]     sum_s;
    logic [N:0]     diff_s;
    logic [SHW-1:0] shamt_s;
    logic           carry_s;
    logic           ovf_s;

    assign sum_s   = {1'b0, a} + {1'b0, b};
    assign diff_s  = {1'b0, a} - {1'b0, b};
    assign shamt_s = b[SHW-1:0];

    // Select the result and the arithmetic carry/overflow for the op code
    always_comb begin
        res     = '0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op)
            ALU_ADD: begin
                res     = sum_s[N-1:0];
                carry_s = sum_s[N];
                ovf_s   = (a[N-1] == b[N-1]) && (sum_s[N-1] != a[N-1]);
            end
            ALU_SUB: begin
                res     = diff_s[N-1:0];
                carry_s = diff_s[N];
                ovf_s   = (a[N-1] != b[N-1]) && (diff_s[N-1] != a[N-1]);
            end
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_SLT:  res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SRA:  res = $unsigned($signed(a) >>> shamt_s);
            ALU_SRL:  res = a >> shamt_s;
            ALU_SLL:  res = a << shamt_s;
            ALU_SLTU: res = {{(N-1){1'b0}}, (a < b)};
            default: begin
                res     = sum_s[N-1:0];
                carry_s = sum_s[N];
                ovf_s   = (a[N-1] == b[N-1]) && (sum_s[N-1] != a[N-1]);
            end
        endcase
    end

    // Assemble the flag vector from the selected result
    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_Z] = (res == '0);
        flags[FLAG_N] = res[N-1];
        flags[FLAG_C] = carry_s;
        flags[FLAG_V] = ovf_s;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer
// (wrapping), and moves the pointer past the winner whenever the grant is
// taken. Wrap arithmetic is explicit so non-power-of-two NREQ works.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic [IDW-1:0] ptr_r;
    logic           found_s;

    function automatic int wrap_idx(input int p, input int k);
        return ((p + k) >= NREQ) ? (p + k - NREQ) : (p + k);
    endfunction

    // Scan upward from the pointer and pick the first active request
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found_s  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req[wrap_idx(int'(ptr_r), k)]) begin
                grant[wrap_idx(int'(ptr_r), k)] = 1'b1;
                grant_id = IDW'(wrap_idx(int'(ptr_r), k));
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Pointer moves to the requester after the winner on each taken grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= (int'(grant_id) == (NREQ - 1)) ? '0 : (grant_id + IDW'(1));
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters. A round-robin
// grant feeds the ALU; the result, flags and winner ID are captured in a
// single response register that can be drained and refilled in one cycle.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_src1,
    input  logic [NREQ*N-1:0] req_src2,
    input  logic [NREQ*4-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_res,
    output logic [3:0]        rsp_flags
);

    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  grant_id_s;
    logic            can_issue_s;
    logic            accept_s;
    logic [N-1:0]    alu_a_s;
    logic [N-1:0]    alu_b_s;
    logic [3:0]      alu_op_s;
    logic [N-1:0]    alu_res_s;
    logic [3:0]      alu_flags_s;
    rsp_state_t      state_r;
    rsp_state_t      state_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .advance  (accept_s),
        .grant    (grant_s),
        .grant_id (grant_id_s)
    );

    alu #(
        .N (N)
    ) u_alu (
        .a     (alu_a_s),
        .b     (alu_b_s),
        .op    (alu_op_s),
        .res   (alu_res_s),
        .flags (alu_flags_s)
    );

    // Accept only when the response slot is free or draining, never in reset
    always_comb begin
        can_issue_s = (state_r == RSP_EMPTY) || rsp_ready;
        if (rst_n) begin
            req_ready = grant_s & {NREQ{can_issue_s}};
        end else begin
            req_ready = '0;
        end
        accept_s = |(req_valid & req_ready);
    end

    // One-hot AND-OR mux of the granted requester's payload into the ALU
    always_comb begin
        alu_a_s  = '0;
        alu_b_s  = '0;
        alu_op_s = 4'b0000;
        for (int i = 0; i < NREQ; i++) begin
            alu_a_s  = alu_a_s  | ({N{grant_s[i]}} & req_src1[i*N +: N]);
            alu_b_s  = alu_b_s  | ({N{grant_s[i]}} & req_src2[i*N +: N]);
            alu_op_s = alu_op_s | ({4{grant_s[i]}} & req_op[i*4 +: 4]);
        end
    end

    // Response slot occupancy: fill on accept, empty on drain without refill
    always_comb begin
        case (state_r)
            RSP_EMPTY: state_s = accept_s ? RSP_FULL : RSP_EMPTY;
            RSP_FULL:  state_s = (rsp_ready && !accept_s) ? RSP_EMPTY : RSP_FULL;
            default:   state_s = RSP_EMPTY;
        endcase
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= RSP_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Response payload: load on accept, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_id    <= '0;
            rsp_res   <= '0;
            rsp_flags <= 4'b0000;
        end else if (accept_s) begin
            rsp_id    <= grant_id_s;
            rsp_res   <= alu_res_s;
            rsp_flags <= alu_flags_s;
        end else begin
            rsp_id    <= rsp_id;
            rsp_res   <= rsp_res;
            rsp_flags <= rsp_flags;
        end
    end

    assign rsp_valid = (state_r == RSP_FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a two-requester instance for the ALU
// table, fairness and backpressure, and a three-requester instance for
// pointer wrap with a gap in the request set.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Two-requester instance
    logic [1:0]  a_valid, a_ready;
    logic [63:0] a_src1, a_src2;
    logic [7:0]  a_op;
    logic        a_rsp_valid, a_rsp_ready;
    logic [0:0]  a_rsp_id;
    logic [31:0] a_rsp_res;
    logic [3:0]  a_rsp_flags;

    // Three-requester instance
    logic [2:0]  b_valid, b_ready;
    logic [95:0] b_src1, b_src2;
    logic [11:0] b_op;
    logic        b_rsp_valid, b_rsp_ready;
    logic [1:0]  b_rsp_id;
    logic [31:0] b_rsp_res;
    logic [3:0]  b_rsp_flags;

    alu_arbiter #(.N(32), .NREQ(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_src1(a_src1), .req_src2(a_src2), .req_op(a_op),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id),
        .rsp_res(a_rsp_res), .rsp_flags(a_rsp_flags)
    );

    alu_arbiter #(.N(32), .NREQ(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_src1(b_src1), .req_src2(b_src2), .req_op(b_op),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_res(b_rsp_res), .rsp_flags(b_rsp_flags)
    );

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic [3:0]  flags;
        logic [3:0]  mask;
    } vec_t;

    vec_t vecs [13];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input int id, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        a_valid = 2'b00;
        a_src1  = '0;
        a_src2  = '0;
        a_op    = '0;
        a_valid[id] = 1'b1;
        a_src1[id*32 +: 32] = x;
        a_src2[id*32 +: 32] = y;
        a_op[id*4 +: 4]     = op;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_ptr;
        int exp_g;
        int j0;
        int j1;
        logic [31:0] exp_res;
        logic [2:0]  exp_b_ready;

        vecs[0]  = '{1, ALU_SUB,  32'd5,          32'd7,          32'hFFFF_FFFE, 4'b0010, 4'b0011};
        vecs[1]  = '{0, ALU_ADD,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000, 4'b1010, 4'b1111};
        vecs[2]  = '{1, ALU_SUB,  32'd3,          32'd3,          32'h0000_0000, 4'b0001, 4'b0011};
        vecs[3]  = '{0, ALU_ADD,  32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 4'b0101, 4'b1111};
        vecs[4]  = '{1, 4'b1010,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000, 4'b1010, 4'b1111};
        vecs[5]  = '{0, ALU_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000, 4'b0010, 4'b0011};
        vecs[6]  = '{1, ALU_OR,   32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF, 4'b0000, 4'b0011};
        vecs[7]  = '{0, ALU_XOR,  32'hFFFF_FFFF,  32'h0000_FFFF,  32'hFFFF_0000, 4'b0010, 4'b0011};
        vecs[8]  = '{1, ALU_SLT,  32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 4'b0000, 4'b0011};
        vecs[9]  = '{0, ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 4'b0001, 4'b0011};
        vecs[10] = '{1, ALU_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000, 4'b0010, 4'b0011};
        vecs[11] = '{0, ALU_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000, 4'b0000, 4'b0011};
        vecs[12] = '{1, ALU_SLL,  32'h0000_0001,  32'd31,         32'h8000_0000, 4'b0010, 4'b0011};

        a_valid = 2'b11; a_src1 = '0; a_src2 = '0; a_op = '0; a_rsp_ready = 1'b1;
        b_valid = 3'b111; b_src1 = '0; b_src2 = '0; b_op = '0; b_rsp_ready = 1'b1;
        rst_n = 1'b0;

        // Reset with everyone requesting
        #1;
        check("reset_ready2", {30'd0, a_ready}, 32'd0);
        check("reset_ready3", {29'd0, b_ready}, 32'd0);
        step();
        check("reset_rsp_valid2", {31'd0, a_rsp_valid}, 32'd0);
        check("reset_rsp_id2", {31'd0, a_rsp_id}, 32'd0);
        check("reset_rsp_res2", a_rsp_res, 32'd0);
        check("reset_rsp_flags2", {28'd0, a_rsp_flags}, 32'd0);
        check("reset_ptr2", {31'd0, dut2.u_rr.ptr_r}, 32'd0);
        check("reset_rsp_valid3", {31'd0, b_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("first_grant_req0", {30'd0, a_ready}, 32'd1);
        a_valid = 2'b00;
        b_valid = 3'b000;

        // ALU table, one requester at a time
        exp_ptr = 0;
        for (int v = 0; v < 13; v++) begin
            drive2(vecs[v].id, vecs[v].op, vecs[v].x, vecs[v].y);
            step();
            check($sformatf("vec%0d_valid", v), {31'd0, a_rsp_valid}, 32'd1);
            check($sformatf("vec%0d_id", v), {31'd0, a_rsp_id}, vecs[v].id);
            check($sformatf("vec%0d_res", v), a_rsp_res, vecs[v].res);
            check($sformatf("vec%0d_flags", v), {28'd0, a_rsp_flags & vecs[v].mask}, {28'd0, vecs[v].flags});
            exp_ptr = (vecs[v].id + 1) % 2;
            check($sformatf("vec%0d_ptr", v), {31'd0, dut2.u_rr.ptr_r}, exp_ptr);
        end

        // Fairness: both requesters valid, back-to-back responses
        a_valid = 2'b11;
        a_op = '0;
        j0 = 0;
        j1 = 0;
        exp_g = 0;
        for (int k = 0; k < 4; k++) begin
            a_src1[31:0]  = 32'd100 + j0; a_src2[31:0]  = 32'd1000;
            a_src1[63:32] = 32'd200 + j1; a_src2[63:32] = 32'd2000;
            exp_g = exp_ptr;
            exp_res = (exp_g == 0) ? (32'd1100 + j0) : (32'd2200 + j1);
            #1;
            check($sformatf("rr%0d_ready", k), {30'd0, a_ready}, 32'd1 << exp_g);
            step();
            check($sformatf("rr%0d_valid", k), {31'd0, a_rsp_valid}, 32'd1);
            check($sformatf("rr%0d_id", k), {31'd0, a_rsp_id}, exp_g);
            check($sformatf("rr%0d_res", k), a_rsp_res, exp_res);
            if (exp_g == 0) j0++; else j1++;
            exp_ptr = (exp_g + 1) % 2;
        end

        // Backpressure with a full response slot
        a_src1[31:0]  = 32'd100 + j0;
        a_src1[63:32] = 32'd200 + j1;
        a_rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d_ready", k), {30'd0, a_ready}, 32'd0);
            step();
            check($sformatf("stall%0d_valid", k), {31'd0, a_rsp_valid}, 32'd1);
            check($sformatf("stall%0d_id", k), {31'd0, a_rsp_id}, exp_g);
            check($sformatf("stall%0d_res", k), a_rsp_res, exp_res);
            check($sformatf("stall%0d_ptr", k), {31'd0, dut2.u_rr.ptr_r}, exp_ptr);
        end
        a_rsp_ready = 1'b1;
        #1;
        check("drain_accept_ready", {30'd0, a_ready}, 32'd1 << exp_ptr);
        step();
        check("drain_accept_valid", {31'd0, a_rsp_valid}, 32'd1);
        check("drain_accept_id", {31'd0, a_rsp_id}, exp_ptr);
        check("drain_accept_res", a_rsp_res, 32'd1100 + j0);
        exp_ptr = (exp_ptr + 1) % 2;
        a_valid = 2'b00;
        step();
        check("idle_drained", {31'd0, a_rsp_valid}, 32'd0);
        check("idle_ptr_held", {31'd0, dut2.u_rr.ptr_r}, exp_ptr);

        // Three requesters, middle one idle: grants 0,2,0,2 with wrap
        b_valid = 3'b101;
        b_src1[31:0] = 32'd1;  b_src2[31:0] = 32'd1;
        b_src1[95:64] = 32'd2; b_src2[95:64] = 32'd2;
        for (int k = 0; k < 4; k++) begin
            exp_g = ((k % 2) == 0) ? 0 : 2;
            exp_b_ready = 3'b001 << exp_g;
            #1;
            check($sformatf("n3_%0d_ready", k), {29'd0, b_ready}, {29'd0, exp_b_ready});
            step();
            check($sformatf("n3_%0d_id", k), {30'd0, b_rsp_id}, exp_g);
            check($sformatf("n3_%0d_res", k), b_rsp_res, (exp_g == 0) ? 32'd2 : 32'd4);
            check($sformatf("n3_%0d_ptr", k), {30'd0, dut3.u_rr.ptr_r}, (exp_g + 1) % 3);
        end
        b_valid = 3'b000;

        // Reset while a response is pending drops it
        drive2(0, ALU_ADD, 32'd9, 32'd9);
        step();
        check("pre_reset_res", a_rsp_res, 32'd18);
        a_rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_ready", {30'd0, a_ready}, 32'd0);
        step();
        check("midreset_valid", {31'd0, a_rsp_valid}, 32'd0);
        check("midreset_res", a_rsp_res, 32'd0);
        check("midreset_ptr", {31'd0, dut2.u_rr.ptr_r}, 32'd0);
        rst_n = 1'b1;
        a_valid = 2'b00;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between `NREQ` requesters, for example the execute stage and the branch/address unit.
- Arbitration is round-robin.
- Each requester has a valid/ready request channel.
- One registered response channel returns the result to the winning requester, tagged with its ID.
- The block sits between the issue logic and the ALU and replaces direct ALU hookups once more than one unit needs it.

## Interface
- `N`, 32, operand/result width (passed to `alu`)
- `NREQ`, 2, number of requesters (≥2)
- `IDW`, `$clog2(NREQ)`, requester ID width
- `clk` input 1 system clock, rising edge
- `rst_n` input 1 reset; one clock, synchronous, active-low
- `req_valid` input NREQ per-requester request valid
- `req_ready` output NREQ per-requester accept
- `req_src1` input NREQ×N packed operand 1 per requester
- `req_src2` input NREQ×N packed operand 2 per requester
- `req_op` input NREQ×4 packed ALU op code per requester
- `rsp_valid` output 1 response valid
- `rsp_ready` input 1 response accept from consumer
- `rsp_id` output IDW index of requester that owns the response
- `rsp_res` output N registered ALU result
- `rsp_flags` output 4 registered flags: [0] zero, [1] negative, [2] carry, [3] overflow

## Operation
Op codes are those of `alu`:
- add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sra 0110, srl 0111, sll 1000, sltu 1001.
- Any other code executes as add.

Internal state and derived signals:
- rr pointer `ptr` (IDW bits); the output register is `rsp_valid/rsp_id/rsp_res/rsp_flags`.
- `can_issue` = !rsp_valid || rsp_ready (output register empty or draining this cycle).
- Grant: the first i with `req_valid[i]`, scanning from `ptr` upward with wrap modulo NREQ. At most one grant per cycle.
- `req_ready[i]` = grant[i] && can_issue. It is combinational from `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`.
- Requesters must not make `req_valid` depend on `req_ready`.
- Once `req_valid[i]` is asserted, it and its payload must stay stable until accepted.

On accept of requester g (`req_valid[g] && req_ready[g]`):
- The ALU is fed g's operands and op.
- `rsp_res`/`rsp_flags` load the ALU outputs.
- `rsp_id` loads g and `rsp_valid` is set.
- `ptr` loads (g+1) mod NREQ. Wrap must be correct for non-power-of-two NREQ.

Otherwise:
- `rsp_valid && rsp_ready` clears `rsp_valid`.
- `rsp_valid && !rsp_ready` holds all response outputs stable.
- `ptr` changes only on accept.

Other rules:
- Simultaneous drain and accept in one cycle: the new response replaces the old one, `rsp_valid` stays 1 and no bubble is inserted.
- No requests valid: no grant, ALU inputs are don't-care, and `ptr` is held.

Response/FSM view, two states:
- EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
- EMPTY→FULL on accept.
- FULL→EMPTY on `rsp_ready` without accept.
- FULL→FULL on stall, or on drain with accept.

## Timing
Reset values while `rst_n`=0 at a rising edge:
- `rsp_valid`=0, `rsp_id`=0, `rsp_res`=0, `rsp_flags`=0, `ptr`=0.
- `req_ready` is forced to all 0 during the reset cycle.

Latency and throughput:
- A request accepted at edge t shows `rsp_valid`=1 from edge t.
- Results are therefore visible the cycle after `req_valid && req_ready`; latency is 1.
- Throughput is one operation per cycle while `rsp_ready`=1.

Fairness: with all requesters continuously valid and `rsp_ready`=1, grants cycle 0,1,…,NREQ-1,0.

Reset mid-operation: a pending response is dropped, nothing is replayed, and requesters must re-present their requests.

## Structure
- Package `alu_pkg`: op-code localparams (`ALU_ADD`, `ALU_SUB`, …, `ALU_SLTU`) and flag bit indices (`FLAG_Z`, `FLAG_N`, `FLAG_C`, `FLAG_V`). Update `alu` callers to use them.
- Natural sub-module: `rr_arbiter` (parameter NREQ).
  - Inputs: `clk`, `rst_n`, `req`, `advance`.
  - Outputs: one-hot `grant` and `grant_id`.
  - It contains `ptr`.
- `alu_arbiter` instantiates `rr_arbiter` and one `alu` and holds the output register.

## Test plan
1. Reset with `req_valid`=2'b11: `req_ready`=0 and `rsp_valid`=0. After release, requester 0 is granted first.
2. Requester 1 only, op 0001, src1=5, src2=7, `rsp_ready`=1: next cycle `rsp_id`=1, `rsp_res`=32'hFFFF_FFFE, flags: neg=1, zero=0.
3. Both requesters valid for 4 cycles with `rsp_ready`=1 and distinct adds: responses return in ID order 0,1,0,1 with correct sums and no bubbles.
4. Backpressure: `rsp_ready`=0 for 3 cycles with response FULL. `rsp_*` stays stable, `req_ready`=0 and `ptr` is unchanged. When `rsp_ready` returns to 1, the pending response drains and the next grant is accepted in the same cycle.
5. Flags:
   - add 32'h7FFF_FFFF+1 gives overflow=1, neg=1.
   - sub 3−3 gives zero=1.
   - add 32'hFFFF_FFFF+1 gives carry=1, zero=1.
   - op 1010 behaves as add.
6. NREQ=3: requesters 0 and 2 valid and 1 idle. Grants alternate 0,2,0,2. `ptr` wraps from 2 to 0 correctly.
